// File: rtl/dcache_arb_pkg.sv
// Shared definitions for the dcache arbiter: access-size codes,
// port id width, dcache read latency and the response tag type.
package dcache_arb_pkg;

    localparam int ACCESS_SZ_W = 3;

    localparam logic [ACCESS_SZ_W-1:0] ACCESS_SZ_BYTE = 3'd0;
    localparam logic [ACCESS_SZ_W-1:0] ACCESS_SZ_HALF = 3'd1;
    localparam logic [ACCESS_SZ_W-1:0] ACCESS_SZ_WORD = 3'd2;

    localparam int ARB_PORT_W    = 1;
    localparam int DCACHE_RD_LAT = 2;

    typedef logic [ARB_PORT_W-1:0] port_id_t;

    typedef struct packed {
        logic     vld;
        port_id_t id;
    } rsp_tag_t;

    // Number of bytes touched by a write of the given size code.
    // Unknown codes behave as a full word.
    function automatic logic [2:0] access_nbytes(
        input logic [ACCESS_SZ_W-1:0] sz
    );
        logic [2:0] nb;
        case (sz)
            ACCESS_SZ_BYTE: nb = 3'd1;
            ACCESS_SZ_HALF: nb = 3'd2;
            default:        nb = 3'd4;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/dcache_arb_rsp_pipe.sv
// Read-response tag pipeline: DEPTH-deep shift register of {valid,id}.
// Ports: clk, rst (async, active-high), in_vld_i/in_id_i (tag of the
// read issued this cycle), out_vld_o/out_id_o (head stage tag).
module dcache_arb_rsp_pipe
    import dcache_arb_pkg::*;
#(
    parameter int DEPTH = DCACHE_RD_LAT
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     in_vld_i,
    input  port_id_t in_id_i,
    output logic     out_vld_o,
    output port_id_t out_id_o
);

    rsp_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= {in_vld_i, in_id_i};
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_vld_o = stage_q[DEPTH-1].vld;
    assign out_id_o  = stage_q[DEPTH-1].id;

endmodule

// File: rtl/dcache_arb.sv
// Two-port dcache arbiter: one read or write per cycle, stalls reads that
// partially overlap the previous cycle's write, routes read data back.
// Ports: clk, rst (async, active-high); per requester N (0=LSU, 1=DMA):
//   pN_req/we/addr/wdata/wsz in, pN_gnt/rvalid/rdata/rhit out;
//   dcache side: dc_re/raddr/we/waddr/wdata/wsz out, dc_rdata/dc_hit in.
// Build option: DCACHE_ARB_RR_EN selects round-robin instead of
// fixed priority (port 0 wins) when both ports are eligible.
module dcache_arb
    import dcache_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SZ_W   = ACCESS_SZ_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [SZ_W-1:0]   p0_wsz,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rhit,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [SZ_W-1:0]   p1_wsz,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rhit,

    output logic              dc_re,
    output logic [ADDR_W-1:0] dc_raddr,
    output logic              dc_we,
    output logic [ADDR_W-1:0] dc_waddr,
    output logic [DATA_W-1:0] dc_wdata,
    output logic [SZ_W-1:0]   dc_wsz,
    input  logic [DATA_W-1:0] dc_rdata,
    input  logic              dc_hit
);

    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];
    logic [SZ_W-1:0]   wsz   [2];

    assign req      = {p1_req, p0_req};
    assign we       = {p1_we, p0_we};
    assign addr[0]  = p0_addr;
    assign addr[1]  = p1_addr;
    assign wdata[0] = p0_wdata;
    assign wdata[1] = p1_wdata;
    assign wsz[0]   = p0_wsz;
    assign wsz[1]   = p1_wsz;

    // Last-write tracker: the write granted in the previous cycle
    logic              lw_vld_q, lw_vld_d;
    logic [ADDR_W-1:0] lw_addr_q, lw_addr_d;
    logic [SZ_W-1:0]   lw_wsz_q, lw_wsz_d;

    logic [2:0]        lw_nb;
    logic [ADDR_W:0]   wr_lo;
    logic [ADDR_W:0]   wr_hi;

    assign lw_nb = access_nbytes(ACCESS_SZ_W'(lw_wsz_q));
    // One extra bit so ranges near the top of memory do not wrap
    assign wr_lo = {1'b0, lw_addr_q};
    assign wr_hi = wr_lo + (ADDR_W+1)'(lw_nb) - (ADDR_W+1)'(1);

    logic [1:0] haz;
    logic [1:0] elig;

    for (genvar n = 0; n < 2; n++) begin : g_haz
        logic [ADDR_W:0] rd_lo;
        logic [ADDR_W:0] rd_hi;
        logic            ovl;

        assign rd_lo = {1'b0, addr[n]};
        assign rd_hi = rd_lo + (ADDR_W+1)'(3);
        assign ovl   = (rd_lo <= wr_hi) && (wr_lo <= rd_hi);
        // Same start address is forwarded inside the dcache, so only
        // a partial overlap has to wait a cycle.
        assign haz[n]  = !we[n] && lw_vld_q && ovl &&
                         (addr[n] != lw_addr_q);
        assign elig[n] = req[n] && !haz[n];
    end

    logic pref;

`ifdef DCACHE_ARB_RR_EN
    logic rr_ptr_q, rr_ptr_d;
    assign pref = rr_ptr_q;
`else
    assign pref = 1'b0;
`endif

    logic gnt_any;
    logic sel;

    always_comb begin
        gnt_any = 1'b0;
        sel     = 1'b0;
        if (!rst) begin
            unique case (elig)
                2'b01: begin
                    gnt_any = 1'b1;
                    sel     = 1'b0;
                end
                2'b10: begin
                    gnt_any = 1'b1;
                    sel     = 1'b1;
                end
                2'b11: begin
                    gnt_any = 1'b1;
                    sel     = pref;
                end
                default: begin
                    gnt_any = 1'b0;
                    sel     = 1'b0;
                end
            endcase
        end
    end

    assign p0_gnt = gnt_any && !sel;
    assign p1_gnt = gnt_any && sel;

    always_comb begin
        dc_re    = 1'b0;
        dc_raddr = '0;
        dc_we    = 1'b0;
        dc_waddr = '0;
        dc_wdata = '0;
        dc_wsz   = '0;
        if (gnt_any) begin
            if (we[sel]) begin
                dc_we    = 1'b1;
                dc_waddr = addr[sel];
                dc_wdata = wdata[sel];
                dc_wsz   = wsz[sel];
            end else begin
                dc_re    = 1'b1;
                dc_raddr = addr[sel];
            end
        end
    end

    assign lw_vld_d  = gnt_any && we[sel];
    assign lw_addr_d = lw_vld_d ? addr[sel] : lw_addr_q;
    assign lw_wsz_d  = lw_vld_d ? wsz[sel]  : lw_wsz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lw_vld_q  <= 1'b0;
            lw_addr_q <= '0;
            lw_wsz_q  <= '0;
        end else begin
            lw_vld_q  <= lw_vld_d;
            lw_addr_q <= lw_addr_d;
            lw_wsz_q  <= lw_wsz_d;
        end
    end

`ifdef DCACHE_ARB_RR_EN
    // Hand preference to the other port after every grant
    assign rr_ptr_d = gnt_any ? !sel : rr_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    logic     rsp_vld;
    port_id_t rsp_id;

    dcache_arb_rsp_pipe #(
        .DEPTH(DCACHE_RD_LAT)
    ) u_rsp_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld_i (gnt_any && !we[sel]),
        .in_id_i  (port_id_t'(sel)),
        .out_vld_o(rsp_vld),
        .out_id_o (rsp_id)
    );

    assign p0_rvalid = rsp_vld && (rsp_id == port_id_t'(0));
    assign p1_rvalid = rsp_vld && (rsp_id == port_id_t'(1));
    assign p0_rdata  = p0_rvalid ? dc_rdata : '0;
    assign p1_rdata  = p1_rvalid ? dc_rdata : '0;
    assign p0_rhit   = p0_rvalid && dc_hit;
    assign p1_rhit   = p1_rvalid && dc_hit;

endmodule

// File: tb/tb_dcache_arb.sv
// Testbench for dcache_arb: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model of the arbiter.
module tb_dcache_arb;
    import dcache_arb_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = 3;
    localparam int MEMSZ = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic [SW-1:0] p0_wsz = '0, p1_wsz = '0;
    logic          p0_gnt, p0_rvalid, p0_rhit;
    logic          p1_gnt, p1_rvalid, p1_rhit;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          dc_re, dc_we, dc_hit;
    logic [AW-1:0] dc_raddr, dc_waddr;
    logic [DW-1:0] dc_wdata, dc_rdata;
    logic [SW-1:0] dc_wsz;

    always #5 clk = ~clk;

    dcache_arb dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_wsz(p0_wsz), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_rhit(p0_rhit),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_wsz(p1_wsz), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_rhit(p1_rhit),
        .dc_re(dc_re), .dc_raddr(dc_raddr), .dc_we(dc_we),
        .dc_waddr(dc_waddr), .dc_wdata(dc_wdata), .dc_wsz(dc_wsz),
        .dc_rdata(dc_rdata), .dc_hit(dc_hit)
    );

    // Behavioural dcache: byte memory, 2-cycle read latency
    logic [7:0]    mem [MEMSZ];
    logic [DW-1:0] rd1_q = '0, rd2_q = '0;
    logic          h1_q = 0, h2_q = 0;

    function automatic int nbytes(input logic [SW-1:0] sz);
        if (sz == ACCESS_SZ_BYTE) return 1;
        if (sz == ACCESS_SZ_HALF) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        int ia;
        if (a >= MEMSZ) return 32'h0;
        ia = int'(a);
        w = '0;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mem[(ia + k) % MEMSZ];
        return w;
    endfunction

    task automatic mem_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [SW-1:0] sz);
        if (a < MEMSZ)
            for (int k = 0; k < nbytes(sz); k++)
                mem[(int'(a) + k) % MEMSZ] = d[8*k +: 8];
    endtask

    always @(posedge clk) begin
        if (dc_we) mem_write(dc_waddr, dc_wdata, dc_wsz);
        rd1_q <= dc_re ? mem_word(dc_raddr) : 32'h0;
        h1_q  <= dc_re && (dc_raddr < MEMSZ);
        rd2_q <= rd1_q;
        h2_q  <= h1_q;
    end

    assign dc_rdata = rd2_q;
    assign dc_hit   = h2_q;

    // Reference model state
    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
        bit          hit;
    } rsp_t;

    rsp_t        rq[$];
    int          cyc = 0;
    bit          m_lw_vld = 0;
    logic [31:0] m_lw_addr = '0;
    int          m_lw_nw = 4;
    bit          m_rr = 0;
    int          last_g = -1;
    logic        obs_g0, obs_g1;
    logic [31:0] obs_rd1;
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d",
                   tag, obs, exp, cyc);
        end
    endtask

    function automatic bit m_haz(input logic we, input logic [31:0] a);
        longint ra, wa;
        ra = longint'(a);
        wa = longint'(m_lw_addr);
        if (we || !m_lw_vld || a == m_lw_addr) return 0;
        return (ra <= wa + m_lw_nw - 1) && (wa <= ra + 3);
    endfunction

    task automatic step();
        bit          e0, e1, gw;
        int          g;
        logic [31:0] ga, gd;
        logic [SW-1:0] gs;
        bit          rv0, rv1;
        logic [31:0] rd0, rd1;
        bit          rh0, rh1;
        @(negedge clk);
        if (rst) rq.delete();
        e0 = p0_req && !m_haz(p0_we, p0_addr);
        e1 = p1_req && !m_haz(p1_we, p1_addr);
        if (rst) g = -1;
`ifdef DCACHE_ARB_RR_EN
        else if (e0 && e1) g = m_rr ? 1 : 0;
`else
        else if (e0 && e1) g = 0;
`endif
        else if (e0) g = 0;
        else if (e1) g = 1;
        else g = -1;
        gw = (g == 0) ? p0_we : (g == 1) ? p1_we : 1'b0;
        ga = (g == 0) ? p0_addr : (g == 1) ? p1_addr : '0;
        gd = (g == 0) ? p0_wdata : (g == 1) ? p1_wdata : '0;
        gs = (g == 0) ? p0_wsz : (g == 1) ? p1_wsz : '0;
        obs_g0 = p0_gnt;
        obs_g1 = p1_gnt;
        obs_rd1 = p1_rdata;
        chk("p0_gnt", 32'(p0_gnt), 32'(g == 0));
        chk("p1_gnt", 32'(p1_gnt), 32'(g == 1));
        chk("dc_re", 32'(dc_re), 32'(g >= 0 && !gw));
        chk("dc_raddr", dc_raddr, (g >= 0 && !gw) ? ga : 32'h0);
        chk("dc_we", 32'(dc_we), 32'(g >= 0 && gw));
        chk("dc_waddr", dc_waddr, gw ? ga : 32'h0);
        chk("dc_wdata", dc_wdata, gw ? gd : 32'h0);
        chk("dc_wsz", 32'(dc_wsz), gw ? 32'(gs) : 32'h0);
        rv0 = 0; rv1 = 0; rd0 = '0; rd1 = '0; rh0 = 0; rh1 = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            rsp_t r;
            r = rq.pop_front();
            if (r.port == 0) begin
                rv0 = 1; rd0 = r.data; rh0 = r.hit;
            end else begin
                rv1 = 1; rd1 = r.data; rh1 = r.hit;
            end
        end
        chk("p0_rvalid", 32'(p0_rvalid), 32'(rv0));
        chk("p0_rdata", p0_rdata, rd0);
        chk("p0_rhit", 32'(p0_rhit), 32'(rh0));
        chk("p1_rvalid", 32'(p1_rvalid), 32'(rv1));
        chk("p1_rdata", p1_rdata, rd1);
        chk("p1_rhit", 32'(p1_rhit), 32'(rh1));
        if (g >= 0 && !gw)
            rq.push_back('{cyc + 2, g, mem_word(ga), ga < MEMSZ});
        @(posedge clk);
        if (rst) begin
            rq.delete();
            m_lw_vld = 0;
            m_rr = 0;
        end else begin
            m_lw_vld = (g >= 0) && gw;
            if (m_lw_vld) begin
                m_lw_addr = ga;
                m_lw_nw = nbytes(gs);
            end
            if (g >= 0) m_rr = (g == 0);
        end
        last_g = g;
        cyc++;
        #1;
    endtask

    task automatic idle();
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
    endtask

    logic [3:0] seq, seq_exp;
    int         stalls;
    bit         held0, held1;

    initial begin
        for (int i = 0; i < MEMSZ; i++) mem[i] = 8'(i * 7 + 3);

        // Reset state
        rst = 1;
        step();
        step();
        #1 rst = 0;
        step();

        // 1: single p0 read
        p0_req = 1; p0_we = 0; p0_addr = 32'h10;
        step();
        idle();
        step();
        step();
        step();

        // 2: word write then same-address read, no stall
        p0_req = 1; p0_we = 1; p0_addr = 32'h20;
        p0_wdata = 32'hA5A5A5A5; p0_wsz = ACCESS_SZ_WORD;
        step();
        idle();
        p1_req = 1; p1_we = 0; p1_addr = 32'h20;
        step();
        chk("t2_gnt", 32'(obs_g1), 32'h1);
        idle();
        step();
        step();
        chk("t2_rdata", obs_rd1, 32'hA5A5A5A5);
        step();

        // 3: byte write at 0x21, read at 0x20 stalls one cycle
        p0_req = 1; p0_we = 1; p0_addr = 32'h21;
        p0_wdata = 32'h0000005A; p0_wsz = ACCESS_SZ_BYTE;
        step();
        idle();
        p1_req = 1; p1_we = 0; p1_addr = 32'h20;
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (obs_g1) break;
            stalls++;
        end
        chk("t3_stall", 32'(stalls), 32'd1);
        idle();
        step();
        step();
        step();

        // 4: both ports read every cycle
        p0_req = 1; p0_we = 0; p0_addr = 32'h40;
        p1_req = 1; p1_we = 0; p1_addr = 32'h80;
        seq = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            seq[i] = obs_g1;
        end
`ifdef DCACHE_ARB_RR_EN
        seq_exp = 4'b1010;
`else
        seq_exp = 4'b0000;
`endif
        chk("t4_seq", 32'(seq), 32'(seq_exp));
        idle();
        step();
        step();
        step();

        // 5: out-of-range read
        p1_req = 1; p1_we = 0; p1_addr = 32'h4000;
        step();
        idle();
        step();
        step();
        step();

        // 6: reset right after a read grant
        p0_req = 1; p0_we = 0; p0_addr = 32'h30;
        step();
        rst = 1;
        #1;
        chk("t6_gnt", 32'(p0_gnt), 32'h0);
        chk("t6_re", 32'(dc_re), 32'h0);
        step();
        idle();
        step();
        rst = 0;
        for (int i = 0; i < 4; i++) step();

        // Random traffic
        held0 = 0; held1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!held0) begin
                p0_req = ($urandom_range(0, 3) != 0);
                p0_we = $urandom_range(0, 1);
                p0_addr = ($urandom_range(0, 15) == 0) ? 32'h4000 :
                          32'($urandom_range(0, 64));
                p0_wdata = $urandom;
                p0_wsz = SW'($urandom_range(0, 3));
            end
            if (!held1) begin
                p1_req = ($urandom_range(0, 1) != 0);
                p1_we = $urandom_range(0, 1);
                p1_addr = 32'($urandom_range(0, 64));
                p1_wdata = $urandom;
                p1_wsz = SW'($urandom_range(0, 3));
            end
            step();
            held0 = p0_req && (last_g != 0);
            held1 = p1_req && (last_g != 1);
        end
        idle();
        step();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
